// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory controller between the MEM-stage data port
// and a single-port, word-wide block RAM with 1-cycle read latency and no
// byte enables.
//
// - Word stores are written straight through and never stall.
// - Loads read the RAM word, extract the lane, and sign- or zero-extend it.
// - Byte and halfword stores do a read-modify-write of the whole word.
//
// The FSM state is the internal signal `state`, of type state_t.
//
// Optional feature, enabled by the DMEM_MISALIGN_TRAP_EN macro:
// - Misaligned halfword and word accesses are trapped.
// - A trapped access issues no RAM strobe and pulses misalign_err.
// - A trapped load returns 0.
// Without the macro:
// - The offending low address bits are ignored.
// - misalign_err is tied low.
//
// Handshake:
// - The CPU presents memread/memwrite with addr/wr_data/sign_mask.
// - stall is combinational. While stall=1 the CPU holds every request
//   input stable.
// - An access is complete in the first cycle with stall=0.
// - rd_valid pulses for one cycle in that cycle for loads, with rd_data
//   already updated.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           addr,
  input  logic [31:0]           wr_data,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [3:0]            sign_mask,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  stall,
  output logic                  misalign_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RMW_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state, state_nx;

  // Access attributes captured when a multi-cycle access leaves IDLE
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  logic                  half_q;
  logic                  word_q;
  logic                  unsigned_q;
  logic [15:0]           wdata_q;

  // Request decode
  logic is_word, is_half, is_load, misalign, capture;
  logic stall_c, en_c, we_c;
  logic [31:0] load_fmt, merged;

  // Size decode: [2] set means word, [1] set alone means half, else byte
  assign is_word = sign_mask[2];
  assign is_half = sign_mask[1] & ~sign_mask[2];
  // Both strobes high is a store, so it never counts as a load
  assign is_load = memread & ~memwrite;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = (memread | memwrite) &
                    ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Bits deliberately ignored: sign_mask[0] is implied by the size code,
  // and the high address bits wrap
  logic unused_bits;
  assign unused_bits = ^{sign_mask[0], addr[31:ADDR_WIDTH+2]};

  // Lane extraction and extension of the returned RAM word
  always_comb begin
    load_fmt = 32'h0;
    if (word_q) begin
      load_fmt = ram_rdata;
    end else if (half_q) begin
      logic [15:0] h;
      h = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      load_fmt = unsigned_q ? {16'h0, h} : {{16{h[15]}}, h};
    end else begin
      logic [7:0] b;
      case (off_q)
        2'd0:    b = ram_rdata[7:0];
        2'd1:    b = ram_rdata[15:8];
        2'd2:    b = ram_rdata[23:16];
        default: b = ram_rdata[31:24];
      endcase
      load_fmt = unsigned_q ? {24'h0, b} : {{24{b[7]}}, b};
    end
  end

  // Merge of the stored lane into the word read back from RAM
  always_comb begin
    merged = ram_rdata;
    if (half_q) begin
      if (off_q[1]) merged[31:16] = wdata_q;
      else          merged[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and RAM strobe logic
  always_comb begin
    state_nx  = state;
    stall_c   = 1'b0;
    en_c      = 1'b0;
    we_c      = 1'b0;
    capture   = 1'b0;
    ram_addr  = addr[ADDR_WIDTH+1:2];
    ram_wdata = wr_data;
    case (state)
      IDLE: begin
        if (memread | memwrite) begin
          if (misalign) begin
            stall_c  = 1'b1;
            capture  = 1'b1;
            state_nx = DONE;
          end else if (memwrite && is_word) begin
            en_c = 1'b1;
            we_c = 1'b1;
          end else if (memwrite) begin
            en_c     = 1'b1;
            stall_c  = 1'b1;
            capture  = 1'b1;
            state_nx = RMW_WAIT;
          end else begin
            en_c     = 1'b1;
            stall_c  = 1'b1;
            capture  = 1'b1;
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall_c  = 1'b1;
        ram_addr = addr_q;
        state_nx = DONE;
      end
      RMW_WAIT: begin
        stall_c   = 1'b1;
        en_c      = 1'b1;
        we_c      = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = merged;
        state_nx  = DONE;
      end
      default: begin
        ram_addr = addr_q;
        state_nx = IDLE;
      end
    endcase
  end

  // Strobes and stall are forced low while reset is asserted
  assign stall  = stall_c & rst_n;
  assign ram_en = en_c & rst_n;
  assign ram_we = we_c & rst_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Capture of the access attributes when leaving IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      off_q      <= 2'b00;
      half_q     <= 1'b0;
      word_q     <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 16'h0;
    end else if (capture) begin
      addr_q     <= addr[ADDR_WIDTH+1:2];
      off_q      <= addr[1:0];
      half_q     <= is_half;
      word_q     <= is_word;
      unsigned_q <= sign_mask[3];
      wdata_q    <= wr_data[15:0];
    end
  end

  // Load result register and the one-cycle completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 32'h0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == RD_WAIT) begin
        rd_data  <= load_fmt;
        rd_valid <= 1'b1;
      end else if (state == IDLE && capture && misalign && is_load) begin
        rd_data  <= 32'h0;
        rd_valid <= 1'b1;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Trap pulse, raised during DONE of a trapped access
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state == IDLE) && capture && misalign;
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl. It uses a behavioural 1-cycle-latency
// RAM model and hand-computed expectations.
// Build with DMEM_MISALIGN_TRAP_EN defined to check the trapping variant.
module tb_data_mem_ctrl;

  localparam int AW = 12;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]   addr, wr_data, rd_data, ram_wdata, ram_rdata;
  logic          memwrite, memread, rd_valid, stall, misalign_err;
  logic          ram_en, ram_we;
  logic [3:0]    sign_mask;
  logic [AW-1:0] ram_addr;

  data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall),
    .misalign_err(misalign_err), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural block RAM plus strobe counters
  logic [31:0] mem [0:(1<<AW)-1];
  int we_cnt = 0;
  int en_cnt = 0;
  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt = en_cnt + 1;
      if (ram_we) begin
        we_cnt = we_cnt + 1;
        mem[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access at a negedge and run it to completion. On return the
  // access is finished and the inputs have been idle for one cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output int stall_cnt, output logic vld,
                        output logic [31:0] data, output logic err);
    memread = rd; memwrite = wr; addr = a; wr_data = d; sign_mask = m;
    #1;
    stall_cnt = 0;
    while (stall === 1'b1 && stall_cnt < 8) begin
      stall_cnt++;
      @(negedge clk); #1;
    end
    vld = rd_valid; data = rd_data; err = misalign_err;
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0;
    #1;
  endtask

  int sc, en0, we0;
  logic v, e;
  logic [31:0] q;

  // Directed sequence
  initial begin
    rst_n = 1'b0; addr = 0; wr_data = 0; memwrite = 0; memread = 0; sign_mask = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    // A request held during reset must not produce strobes
    memread = 1'b1; sign_mask = 4'b0111; #1;
    chk("rst_en_forced", {31'h0, ram_en}, 32'h0);
    chk("rst_stall_forced", {31'h0, stall}, 32'h0);
    memread = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("post_rst_en", {31'h0, ram_en}, 32'h0);
    chk("post_rst_stall", {31'h0, stall}, 32'h0);
    chk("misalign_idle", {31'h0, misalign_err}, 32'h0);
    @(negedge clk);

    // Sub-word loads from 0x8070_F0FF
    mem[0] = 32'h8070_F0FF;
    access(1'b1, 1'b0, 32'h1, 32'h0, 4'b0001, sc, v, q, e);
    chk("lb_stall_cycles", sc, 2);
    chk("lb_valid", {31'h0, v}, 32'h1);
    chk("lb_data", q, 32'hFFFF_FFF0);
    chk("lb_valid_pulse", {31'h0, rd_valid}, 32'h0);
    chk("lb_data_held", rd_data, 32'hFFFF_FFF0);
    access(1'b1, 1'b0, 32'h1, 32'h0, 4'b1001, sc, v, q, e);
    chk("lbu_data", q, 32'h0000_00F0);
    access(1'b1, 1'b0, 32'h3, 32'h0, 4'b0001, sc, v, q, e);
    chk("lb3_data", q, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 32'h2, 32'h0, 4'b1011, sc, v, q, e);
    chk("lhu2_data", q, 32'h0000_8070);

    // Read-modify-write stores
    mem[0] = 32'h1122_3344;
    access(1'b0, 1'b1, 32'h2, 32'h0000_00AB, 4'b0001, sc, v, q, e);
    chk("sb_stall_cycles", sc, 2);
    chk("sb_no_valid", {31'h0, v}, 32'h0);
    chk("sb_mem", mem[0], 32'h11AB_3344);
    access(1'b0, 1'b1, 32'h0, 32'h1234_BEEF, 4'b0011, sc, v, q, e);
    chk("sh_stall_cycles", sc, 2);
    chk("sh_mem", mem[0], 32'h11AB_BEEF);
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'b0011, sc, v, q, e);
    chk("lh_data", q, 32'hFFFF_BEEF);
    // Both strobes high: handled as a store, no load completion
    access(1'b1, 1'b1, 32'h3, 32'h0000_005A, 4'b0001, sc, v, q, e);
    chk("rw_no_valid", {31'h0, v}, 32'h0);
    chk("rw_mem", mem[0], 32'h5AAB_BEEF);

    // Back-to-back word stores never stall
    memwrite = 1'b1; sign_mask = 4'b0111; addr = 32'h8; wr_data = 32'hDEAD_BEEF; #1;
    chk("sw1_stall", {31'h0, stall}, 32'h0);
    chk("sw1_we", {31'h0, ram_we}, 32'h1);
    @(negedge clk);
    addr = 32'hC; wr_data = 32'hCAFE_F00D; #1;
    chk("sw2_stall", {31'h0, stall}, 32'h0);
    chk("sw2_addr", {20'h0, ram_addr}, 32'h3);
    @(negedge clk);
    memwrite = 1'b0; #1;
    chk("sw1_mem", mem[2], 32'hDEAD_BEEF);
    chk("sw2_mem", mem[3], 32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'b0111, sc, v, q, e);
    chk("lw_data", q, 32'hDEAD_BEEF);
    // High address bits wrap onto the same word
    access(1'b1, 1'b0, 32'h0001_400C, 32'h0, 4'b0111, sc, v, q, e);
    chk("lw_wrap", q, 32'hCAFE_F00D);

    // Reset pulled during RMW_WAIT drops the write
    mem[1] = 32'h5566_7788;
    we0 = we_cnt;
    memwrite = 1'b1; sign_mask = 4'b0001; addr = 32'h5; wr_data = 32'h99;
    @(negedge clk); #1;
    chk("rmw_stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b0; #1;
    chk("rmw_rst_we", {31'h0, ram_we}, 32'h0);
    @(negedge clk);
    memwrite = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rmw_rst_we_cnt", we_cnt, we0);
    chk("rmw_rst_mem", mem[1], 32'h5566_7788);
    chk("rmw_rst_valid", {31'h0, rd_valid}, 32'h0);
    chk("rmw_rst_stall", {31'h0, stall}, 32'h0);
    access(1'b1, 1'b0, 32'h5, 32'h0, 4'b1001, sc, v, q, e);
    chk("post_rst_lbu", q, 32'h0000_0077);

    // Misaligned halfword load
    mem[0] = 32'h8070_F0FF;
    en0 = en_cnt;
    access(1'b1, 1'b0, 32'h3, 32'h0, 4'b0011, sc, v, q, e);
    chk("lh3_valid", {31'h0, v}, 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lh3_stall_cycles", sc, 1);
    chk("lh3_data", q, 32'h0);
    chk("lh3_err", {31'h0, e}, 32'h1);
    chk("lh3_no_en", en_cnt, en0);
    chk("lh3_err_pulse", {31'h0, misalign_err}, 32'h0);
`else
    chk("lh3_stall_cycles", sc, 2);
    chk("lh3_data", q, 32'hFFFF_8070);
    chk("lh3_err", {31'h0, e}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller sitting directly downstream of the pipeline's MEM-stage data port, between the CPU (`data_mem_addr`/`WrData`/`memwrite`/`memread`/`sign_mask`) and a single-port, word-wide block RAM with 1-cycle read latency and no byte enables. It formats sub-word loads (sign/zero extension) and performs read-modify-write for byte and halfword stores. It asserts `stall` to freeze the pipeline while a multi-cycle access is in flight.

## Interface
- `ADDR_WIDTH`, 12, word-address width of the RAM (RAM depth = 2^ADDR_WIDTH words).
- `clk  in  1` — sole clock; all state changes on rising edge.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `addr  in  32` — byte address from CPU; bits above `ADDR_WIDTH+1` ignored (wrap).
- `wr_data  in  32` — store data; relevant bits right-aligned.
- `memwrite  in  1` — store request; held stable by CPU while `stall`=1.
- `memread  in  1` — load request; held stable while `stall`=1.
- `sign_mask  in  4` — [3]=unsigned load; [2:0]: 3'b001 byte, 3'b011 half, 3'b111 word.
- `rd_data  out  32` — registered, formatted load result.
- `rd_valid  out  1` — one-cycle pulse: `rd_data` updated.
- `stall  out  1` — combinational; high while access incomplete.
- `misalign_err  out  1` — one-cycle pulse on trapped misaligned access (tied 0 without macro).
- `ram_addr  out  ADDR_WIDTH` — word address = `addr[ADDR_WIDTH+1:2]`.
- `ram_en  out  1`, `ram_we  out  1`, `ram_wdata  out  32`, `ram_rdata  in  32` (valid the cycle after `ram_en` with `ram_we`=0).

## Operation
- States: IDLE, RD_WAIT, RMW_WAIT, DONE.
- IDLE, no request: all RAM strobes 0, `stall`=0.
- IDLE, word store: `ram_en`=`ram_we`=1, `ram_wdata`=`wr_data`; `stall`=0; stay IDLE.
- IDLE, load: `ram_en`=1, `ram_we`=0, `stall`=1; capture offset/mask; → RD_WAIT.
- IDLE, byte/half store: read issued as for load, `stall`=1; capture data/offset/mask; → RMW_WAIT.
- `memread` and `memwrite` both high: treated as store; `rd_valid` not raised.
- RD_WAIT: `stall`=1; extract lane (byte `addr[1:0]`, half `addr[1]`), sign-extend unless `sign_mask[3]`; register into `rd_data`; → DONE.
- RMW_WAIT: `stall`=1; merge stored lane into `ram_rdata`; drive `ram_en`=`ram_we`=1 with merged word; → DONE.
- DONE: `stall`=0; `rd_valid`=1 if the access was a load; request inputs ignored; → IDLE.

## Timing
- Reset: state IDLE, `rd_data`=0, `rd_valid`=0, `misalign_err`=0; `stall`, `ram_en`, `ram_we` forced 0 while `rst_n`=0.
- Load: 3 cycles (IDLE, RD_WAIT, DONE); `stall` high for exactly 2 cycles; `rd_data` valid from DONE until the next load completes.
- Sub-word store: 3 cycles; RAM write occurs in RMW_WAIT; `stall` high 2 cycles.
- Word store: 0 stall cycles; back-to-back word stores sustain one per cycle.
- Reset mid-access: pending RMW write dropped (no `ram_we`), `rd_valid` not raised, state → IDLE.
- `ram_wdata` is don't-care when `ram_we`=0.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: a half access with `addr[0]`=1 or a word access with `addr[1:0]`≠0 issues no RAM strobe. `stall`=1 in IDLE, then → DONE. In DONE, `misalign_err`=1. For a load, `rd_data`←0 and `rd_valid`=1.
- Undefined: the offending low address bits are ignored (half uses `addr[1]` only, word uses neither); `misalign_err` tied 0.

## Test plan
- Reset: assert `rst_n`=0 mid-sim, release → `stall`=0, `rd_data`=0, `ram_en`=0 on first cycle.
- RAM[0]=0x8070_F0FF; LB addr 0x1 (mask 4'b0001) → `rd_data`=0xFFFF_FFF0, `rd_valid` in cycle 3; LBU (4'b1001) → 0x0000_00F0.
- RAM[0]=0x1122_3344; SB 0xAB at addr 0x2 → RAM[0]=0x11AB_3344; `stall` high exactly 2 cycles; SH 0xBEEF at addr 0x0 → 0x11AB_BEEF.
- SW 0xDEAD_BEEF at 0x8 then 0xCAFE_F00D at 0xC on consecutive cycles → `stall` never high; LW 0x8 → 0xDEAD_BEEF.
- SB in progress, pull `rst_n` low during RMW_WAIT → no `ram_we` observed, RAM word unchanged.
- RAM[0]=0x8070_F0FF, LH addr 0x3: with macro → no `ram_en`, `misalign_err` pulse, `rd_data`=0; without → `rd_data`=0xFFFF_8070.
